// File: rtl/lstm_axi_pkg.sv
// Shared FSM state encoding and AXI response/sideband constants for the LSTM AXI4-Lite master.
package lstm_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LSTM,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_RSP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] AXI_PROT = 3'b000;
   localparam logic [3:0] AXI_STRB = 4'b1111;

endpackage

// File: rtl/lstm_axi4_lite_master.sv
// Command-stream to AXI4-Lite master bridge for the LSTM layers slave, one transaction in flight.
// Optional LSTM_MASTER_TIMEOUT_EN bounds the wait for lstm_valid to TIMEOUT cycles.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// WAIT_LSTM  | read held until lstm_valid (or timeout when enabled)
// WR_REQ     | awvalid/wvalid driven, each drops after its own handshake
// WR_RESP    | bready high, waiting for bvalid
// RD_REQ     | arvalid driven until arready
// RD_DATA    | rready high, waiting for rvalid
// RSP        | rsp_valid high, payload frozen until rsp_ready
module lstm_axi4_lite_master
   import lstm_axi_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic             cmd_wait,
   input  logic [31:0]      cmd_addr,
   input  logic [WIDTH-1:0] cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_write,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic [1:0]       rsp_resp,
   output logic [31:0]      awaddr,
   output logic [2:0]       awprot,
   output logic             awvalid,
   input  logic             awready,
   output logic [WIDTH-1:0] wdata,
   output logic [3:0]       wstrb,
   output logic             wvalid,
   input  logic             wready,
   input  logic [1:0]       bresp,
   input  logic             bvalid,
   output logic             bready,
   output logic [31:0]      araddr,
   output logic [2:0]       arprot,
   output logic             arvalid,
   input  logic             arready,
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       rresp,
   input  logic             rvalid,
   output logic             rready,
   input  logic             lstm_ready,
   input  logic             lstm_valid
);

   state_e           state_q;
   logic             cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic             rsp_valid_q, rsp_write_q;
   logic [WIDTH-1:0] rsp_rdata_q, wdata_q;
   logic [1:0]       rsp_resp_q;
   logic [31:0]      addr_q;
   logic             aw_done, w_done;
   logic             unused_ok;

`ifdef LSTM_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_q;
   assign unused_ok = lstm_ready;
`else
   // lstm_ready is only visible to software; it never gates the bus.
   assign unused_ok = lstm_ready ^ (TIMEOUT == 0);
`endif

   assign aw_done = !awvalid_q || awready;
   assign w_done  = !wvalid_q || wready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
         wdata_q     <= '0;
         addr_q      <= '0;
`ifdef LSTM_MASTER_TIMEOUT_EN
         timer_q     <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= cmd_addr;
                  wdata_q     <= cmd_wdata;
                  if (cmd_write) begin
                     state_q   <= ST_WR_REQ;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else if (cmd_wait) begin
                     state_q <= ST_WAIT_LSTM;
`ifdef LSTM_MASTER_TIMEOUT_EN
                     timer_q <= TW'(TIMEOUT - 1);
`endif
                  end else begin
                     state_q   <= ST_RD_REQ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            ST_WAIT_LSTM: begin
               if (lstm_valid) begin
                  state_q   <= ST_RD_REQ;
                  arvalid_q <= 1'b1;
               end
`ifdef LSTM_MASTER_TIMEOUT_EN
               else if (timer_q == '0) begin
                  state_q     <= ST_RSP;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= RESP_SLVERR;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
`endif
            end
            ST_WR_REQ: begin
               if (awvalid_q && awready) awvalid_q <= 1'b0;
               if (wvalid_q && wready)   wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  state_q  <= ST_WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (bvalid) begin
                  state_q     <= ST_RSP;
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= bresp;
               end
            end
            ST_RD_REQ: begin
               if (arready) begin
                  state_q   <= ST_RD_DATA;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (rvalid) begin
                  state_q     <= ST_RSP;
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b0;
                  rsp_rdata_q <= rdata;
                  rsp_resp_q  <= rresp;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign awaddr    = addr_q;
   assign araddr    = addr_q;
   assign wdata     = wdata_q;
   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign awprot    = AXI_PROT;
   assign arprot    = AXI_PROT;
   assign wstrb     = AXI_STRB;

endmodule

// File: tb/tb_lstm_axi4_lite_master.sv
// Directed self-checking bench for lstm_axi4_lite_master; timeout case runs only with LSTM_MASTER_TIMEOUT_EN.
module tb_lstm_axi4_lite_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_wait;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic        lstm_ready, lstm_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lstm_axi4_lite_master #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_wait(cmd_wait), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .lstm_ready(lstm_ready), .lstm_valid(lstm_valid)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_all_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      chk({tag, "_awvalid"}, awvalid, 1'b0);
      chk({tag, "_wvalid"}, wvalid, 1'b0);
      chk({tag, "_arvalid"}, arvalid, 1'b0);
      chk({tag, "_bready"}, bready, 1'b0);
      chk({tag, "_rready"}, rready, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      chk({tag, "_rsp_resp"}, rsp_resp, 2'b00);
      chk({tag, "_rsp_write"}, rsp_write, 1'b0);
   endtask

   // Zero-wait slave write: command cycle, AW/W beat, B beat, rsp_valid on the fourth cycle.
   task automatic do_write_zero_wait(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br);
      chk("wz_cmd_ready_pre", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wait = 1'b0; cmd_addr = a; cmd_wdata = d;
      awready = 1'b1; wready = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("wz_awvalid", awvalid, 1'b1);
      chk("wz_wvalid", wvalid, 1'b1);
      chk("wz_awaddr", awaddr, a);
      chk("wz_wdata", wdata, d);
      chk("wz_cmd_ready_busy", cmd_ready, 1'b0);
      step();
      chk("wz_awvalid_drop", awvalid, 1'b0);
      chk("wz_wvalid_drop", wvalid, 1'b0);
      chk("wz_bready", bready, 1'b1);
      chk("wz_rsp_not_early", rsp_valid, 1'b0);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = br;
      step();
      chk("wz_rsp_valid", rsp_valid, 1'b1);
      chk("wz_rsp_write", rsp_write, 1'b1);
      chk("wz_rsp_resp", rsp_resp, br);
      chk("wz_rsp_rdata", rsp_rdata, 32'h0);
      chk("wz_bready_drop", bready, 1'b0);
      bvalid = 1'b0; rsp_ready = 1'b1;
      step();
      chk("wz_rsp_done", rsp_valid, 1'b0);
      chk("wz_cmd_ready_back", cmd_ready, 1'b1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_wait = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
      arready = 0; rdata = 0; rresp = 0; rvalid = 0; lstm_ready = 0; lstm_valid = 0;

      // Reset values and constant sideband signals
      step(); step();
      chk_all_idle_outputs("rst");
      rst = 1'b1;
      step();
      chk("rst_release_cmd_ready", cmd_ready, 1'b1);
      chk("awprot", awprot, 3'b000);
      chk("arprot", arprot, 3'b000);
      chk("wstrb", wstrb, 4'b1111);

      // Write 0x10 / 0xDEADBEEF, zero-wait slave
      do_write_zero_wait(32'h10, 32'hDEADBEEF, 2'b00);

      // Write with wready three cycles after awready, DECERR passed through
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'hA5A50001;
      awready = 1'b1; wready = 1'b0;
      step();
      cmd_valid = 1'b0;
      chk("w3_awvalid", awvalid, 1'b1);
      chk("w3_wvalid", wvalid, 1'b1);
      step();
      awready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("w3_awvalid_dropped", awvalid, 1'b0);
         chk("w3_wvalid_held", wvalid, 1'b1);
         chk("w3_wdata_stable", wdata, 32'hA5A50001);
         chk("w3_no_bready", bready, 1'b0);
         if (i < 2) step();
      end
      wready = 1'b1;
      step();
      wready = 1'b0;
      chk("w3_wvalid_drop", wvalid, 1'b0);
      chk("w3_bready", bready, 1'b1);
      bvalid = 1'b1; bresp = 2'b11;
      step();
      bvalid = 1'b0; bresp = 2'b00;
      chk("w3_rsp_valid", rsp_valid, 1'b1);
      chk("w3_rsp_write", rsp_write, 1'b1);
      chk("w3_rsp_resp", rsp_resp, 2'b11);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("w3_rsp_done", rsp_valid, 1'b0);
      step();
      chk("w3_single_rsp", rsp_valid, 1'b0);
      chk("w3_no_rewrite", awvalid, 1'b0);

      // Read 0x20 with cmd_wait, lstm_valid 10 cycles later, rsp_ready stalled 5 cycles
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wait = 1'b1; cmd_addr = 32'h20;
      lstm_ready = 1'b1;
      step();
      cmd_valid = 1'b0; lstm_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("rw_no_arvalid", arvalid, 1'b0);
         chk("rw_cmd_ready", cmd_ready, 1'b0);
         if (i < 9) step();
      end
      lstm_valid = 1'b1;
      step();
      lstm_valid = 1'b0;
      chk("rw_arvalid", arvalid, 1'b1);
      chk("rw_araddr", araddr, 32'h20);
      step();
      chk("rw_arvalid_held", arvalid, 1'b1);
      chk("rw_araddr_stable", araddr, 32'h20);
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rw_arvalid_drop", arvalid, 1'b0);
      chk("rw_rready", rready, 1'b1);
      rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
      step();
      rvalid = 1'b0; rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("rs_rsp_valid", rsp_valid, 1'b1);
         chk("rs_rsp_rdata", rsp_rdata, 32'h12345678);
         chk("rs_rsp_write", rsp_write, 1'b0);
         chk("rs_rsp_resp", rsp_resp, 2'b00);
         chk("rs_cmd_ready", cmd_ready, 1'b0);
         chk("rs_rready_drop", rready, 1'b0);
         if (i < 4) step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rs_rsp_done", rsp_valid, 1'b0);
      chk("rs_cmd_ready_back", cmd_ready, 1'b1);

      // Read without wait, SLVERR passed through, 4-cycle latency
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wait = 1'b0; cmd_addr = 32'h24;
      step();
      cmd_valid = 1'b0;
      chk("rn_arvalid", arvalid, 1'b1);
      chk("rn_araddr", araddr, 32'h24);
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rn_rready", rready, 1'b1);
      chk("rn_rsp_not_early", rsp_valid, 1'b0);
      rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b10;
      step();
      rvalid = 1'b0; rresp = 2'b00;
      chk("rn_rsp_valid", rsp_valid, 1'b1);
      chk("rn_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("rn_rsp_resp", rsp_resp, 2'b10);
      chk("rn_rsp_write", rsp_write, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rn_cmd_ready_back", cmd_ready, 1'b1);

      // Asynchronous reset in WR_RESP, then a fresh write
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h11112222;
      awready = 1'b1; wready = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      awready = 1'b0; wready = 1'b0;
      chk("ar_in_wr_resp", bready, 1'b1);
      chk("ar_prev_rsp_resp", rsp_resp, 2'b10);
      #2 rst = 1'b0;
      #1;
      chk_all_idle_outputs("ar");
      step();
      chk("ar_held_bready", bready, 1'b0);
      rst = 1'b1;
      step();
      chk("ar_release_cmd_ready", cmd_ready, 1'b1);
      do_write_zero_wait(32'h54, 32'h33334444, 2'b10);

      // Read with cmd_wait while lstm_valid already high: one cycle in WAIT_LSTM
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wait = 1'b1; cmd_addr = 32'h28;
      lstm_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("lv_wait_cycle", arvalid, 1'b0);
      step();
      lstm_valid = 1'b0;
      chk("lv_arvalid", arvalid, 1'b1);
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h0BADF00D;
      step();
      rvalid = 1'b0;
      chk("lv_rsp_rdata", rsp_rdata, 32'h0BADF00D);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

`ifdef LSTM_MASTER_TIMEOUT_EN
      // Timeout after 8 wait cycles with lstm_valid stuck low
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wait = 1'b1; cmd_addr = 32'h30;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("to_no_arvalid", arvalid, 1'b0);
         chk("to_no_rsp", rsp_valid, 1'b0);
         step();
      end
      chk("to_rsp_valid", rsp_valid, 1'b1);
      chk("to_rsp_resp", rsp_resp, 2'b10);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_rsp_write", rsp_write, 1'b0);
      chk("to_no_arvalid_end", arvalid, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("to_cmd_ready_back", cmd_ready, 1'b1);
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lstm_axi4_lite_master.md
LSTM_AXI4_LITE_MASTER -- requirements
Module: lstm_axi4_lite_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32: AXI data width and command/response data width.
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum cycles to wait for lstm_valid (used only under REQ-030).
REQ-003 SHALL have ports clk (input, 1, the single clock) and rst (input, 1): reset is asynchronous and active-low.
REQ-004 SHALL have command ports: cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1; 1=write, 0=read), cmd_wait (in, 1; read waits for lstm_valid), cmd_addr (in, 32), cmd_wdata (in, WIDTH).
REQ-005 SHALL have response ports: rsp_valid (out, 1), rsp_ready (in, 1), rsp_write (out, 1), rsp_rdata (out, WIDTH), rsp_resp (out, 2).
REQ-006 SHALL have AXI4-Lite master ports: awaddr (out, 32), awprot (out, 3), awvalid (out, 1), awready (in, 1), wdata (out, WIDTH), wstrb (out, 4), wvalid (out, 1), wready (in, 1), bresp (in, 2), bvalid (in, 1), bready (out, 1).
REQ-007 SHALL have AXI4-Lite master ports: araddr (out, 32), arprot (out, 3), arvalid (out, 1), arready (in, 1), rdata (in, WIDTH), rresp (in, 2), rvalid (in, 1), rready (out, 1).
REQ-008 SHALL have LSTM status inputs lstm_ready (in, 1) and lstm_valid (in, 1), driven by the downstream LSTM layers slave.

Function
REQ-009 SHALL implement states IDLE, WAIT_LSTM, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready and latched (addr, wdata, write, wait).
REQ-011 IDLE transitions: write -> WR_REQ; read with cmd_wait=0 -> RD_REQ; read with cmd_wait=1 -> WAIT_LSTM.
REQ-012 WR_REQ SHALL assert awvalid and wvalid together on the next cycle; each SHALL deassert independently after its own handshake; state -> WR_RESP once both handshakes are done, including same-cycle completion.
REQ-013 Once asserted, awvalid/wvalid/arvalid SHALL NOT drop, and their payloads SHALL stay stable, until the matching ready is seen.
REQ-014 WR_RESP SHALL hold bready=1; on bvalid it SHALL capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, and go -> RSP.
REQ-015 WAIT_LSTM SHALL go -> RD_REQ on the first cycle lstm_valid=1 (lstm_valid already high on entry: one cycle in WAIT_LSTM).
REQ-016 RD_REQ SHALL assert arvalid until arready, then go -> RD_DATA.
REQ-017 RD_DATA SHALL hold rready=1; on rvalid it SHALL capture rdata/rresp, set rsp_write=0, and go -> RSP.
REQ-018 RSP SHALL assert rsp_valid, holding payload stable until rsp_ready, then go -> IDLE; a new command is accepted no earlier than the next cycle.
REQ-019 awprot and arprot SHALL be constant 3'b000; wstrb SHALL be constant 4'b1111.
REQ-020 SHALL keep one transaction outstanding at most; minimum command-to-rsp_valid latency with zero-wait slave is 4 cycles for a write and 4 for a read (cmd_wait=0).
REQ-021 SHALL pass non-OKAY bresp/rresp through unchanged and SHALL NOT retry.
REQ-022 lstm_ready SHALL NOT gate any transaction; it is exposed only for software polling via the command stream.

Reset
REQ-023 While rst=0: state=IDLE and cmd_ready=0, awvalid=wvalid=arvalid=bready=rready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_write=0.
REQ-024 Any in-flight transaction SHALL be abandoned on reset assertion.
REQ-025 After rst rises, cmd_ready=1 in the first clock edge in IDLE.

Configuration
REQ-030 With LSTM_MASTER_TIMEOUT_EN defined: a counter SHALL run in WAIT_LSTM; after TIMEOUT cycles without lstm_valid it SHALL skip the AXI read and go -> RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_write=0.
REQ-031 Without LSTM_MASTER_TIMEOUT_EN: WAIT_LSTM SHALL wait indefinitely and no counter SHALL be synthesised.

Structure
REQ-032 SHALL place the state enum and response codes (OKAY=2'b00, SLVERR=2'b10) in shared package lstm_axi_pkg.
REQ-033 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-034 Write addr 0x10, data 0xDEADBEEF, slave awready/wready same cycle -> one AW/W beat, rsp_valid with rsp_write=1, rsp_resp=00 after 4 cycles.
REQ-035 Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held 3 cycles, single response.
REQ-036 Read addr 0x20, cmd_wait=1, lstm_valid rises 10 cycles later, rdata 0x12345678 -> arvalid appears only after lstm_valid, rsp_rdata=0x12345678.
REQ-037 Macro on, TIMEOUT=8, cmd_wait=1, lstm_valid stuck 0 -> no arvalid, rsp_resp=10 after 8 wait cycles.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp payload stable, cmd_ready=0 throughout.
REQ-039 rst=0 asserted mid-WR_RESP -> all outputs at reset values immediately (asynchronous), next command accepted after release.
